// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst ownership for one FIFO; optional stats via FIFO_ARB_STATS_EN.
// Latency: zero; ack/fifo_wr/fifo_wr_data are combinational from req in the same cycle.
// Backpressure: fifo_full blocks all acks and freezes owner/burst count until it clears.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   data_in,
   output logic [N_REQ-1:0]          ack,
   input  logic                      fifo_full,
   output logic                      fifo_wr,
   output logic [DATA_W-1:0]         fifo_wr_data,
   output logic                      owner_vld,
   output logic [2:0]                owner_id,
   input  logic [2:0]                stat_sel,
   input  logic                      stat_clr,
   output logic [15:0]               stat_cnt
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t     state_q, state_d;
   logic [2:0] owner_q, owner_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] last_q, last_d;

   logic       req_owner;
   logic       hold;
   logic       cand_vld;
   logic [2:0] cand;
   logic       accept;

   // Owner keeps the port while it still requests and has burst budget left;
   // otherwise search round-robin starting just past the last accepted writer.
   always_comb begin
      req_owner = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == 3'(i)) req_owner = req[i];
      end
      hold     = (state_q == OWN) && req_owner && (cnt_q < 4'(MAX_BURST));
      cand_vld = 1'b0;
      cand     = 3'd0;
      for (int k = N_REQ; k >= 1; k--) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (i == (int'(last_q) + k) % N_REQ)) begin
               cand_vld = 1'b1;
               cand     = 3'(i);
            end
         end
      end
      if (hold) begin
         cand_vld = 1'b1;
         cand     = owner_q;
      end
   end

   assign accept = cand_vld && !fifo_full && reset;

   always_comb begin
      ack          = '0;
      fifo_wr_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (accept && (cand == 3'(i))) begin
            ack[i]       = 1'b1;
            fifo_wr_data = data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   assign fifo_wr = accept;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (accept) begin
         state_d = OWN;
         last_d  = cand;
         if (hold) begin
            cnt_d = cnt_q + 4'd1;
         end else begin
            owner_d = cand;
            cnt_d   = 4'd1;
         end
      end else if ((state_q == OWN) && (req == '0)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= 3'd0;
         cnt_q   <= 4'd0;
         last_q  <= 3'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign owner_vld = (state_q == OWN);
   assign owner_id  = owner_q;

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] stat_q [N_REQ];
   logic [15:0] stat_d [N_REQ];

   // Clear takes priority over a same-cycle increment; counters stick at all-ones.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         stat_d[i] = stat_q[i];
         if (stat_clr) begin
            stat_d[i] = 16'h0;
         end else if (ack[i] && (stat_q[i] != 16'hFFFF)) begin
            stat_d[i] = stat_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_REQ; i++) stat_q[i] <= 16'h0;
      end else begin
         for (int i = 0; i < N_REQ; i++) stat_q[i] <= stat_d[i];
      end
   end

   always_comb begin
      stat_cnt = 16'h0;
      for (int i = 0; i < N_REQ; i++) begin
         if (stat_sel == 3'(i)) stat_cnt = stat_q[i];
      end
   end
`else
   logic unused_stat;
   assign unused_stat = ^{stat_sel, stat_clr};
   assign stat_cnt    = 16'h0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, randomized run vs reference model.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*W-1:0] data_in = '0;
   logic [N-1:0]  ack;
   logic          fifo_full = 1'b0;
   logic          fifo_wr;
   logic [W-1:0]  fifo_wr_data;
   logic          owner_vld;
   logic [2:0]    owner_id;
   logic [2:0]    stat_sel = '0;
   logic          stat_clr = 1'b0;
   logic [15:0]   stat_cnt;

   int checks = 0;
   int failures = 0;

   fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
      .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data),
      .owner_vld(owner_vld), .owner_id(owner_id),
      .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic       full;
      logic [3:0] ack;
      logic [7:0] dat;
      logic       vld;
      logic [2:0] id;
   } vec_t;

   vec_t tbl[$];

   // reference model state
   int m_vld, m_id, m_cnt, m_last;
   int m_stat[N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rst, logic [3:0] r, logic f, logic [3:0] a,
                               logic [7:0] d, logic v, logic [2:0] id);
      vec_t t;
      t.rst = rst; t.req = r; t.full = f; t.ack = a; t.dat = d; t.vld = v; t.id = id;
      return t;
   endfunction

   task automatic model_reset();
      m_vld = 0; m_id = 0; m_cnt = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; req = '0; fifo_full = 1'b0; stat_clr = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      vec_t v;
      int cand, exp_ack, exp_dat, exp_stat, keep;
      logic [31:0] rdat;

      // --- 1: reset holds everything quiet even with all requests up
      reset = 1'b0; req = 4'hF; data_in = 32'hA3A2A1A0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ack", ack, 0);
      check("rst_wr", fifo_wr, 0);
      check("rst_vld", owner_vld, 0);
      check("rst_id", owner_id, 0);
      check("rst_dat", fifo_wr_data, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_first_ack", ack, 4'b0001);
      model_reset();

      // --- 2: single requester streams with no bubble at burst boundary
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req = 4'b0001; data_in = {24'h0, 8'(8'h10 + i)};
         #1;
         check("solo_ack", ack, 4'b0001);
         check("solo_dat", fifo_wr_data, 8'h10 + i);
      end

      // --- table: burst rotation, full stall, drop-after-ack wrap
      tbl.push_back(mk(1, 4'h3, 0, 4'h1, 8'hA0, 0, 0));
      tbl.push_back(mk(0, 4'h3, 0, 4'h1, 8'hA0, 1, 0));
      tbl.push_back(mk(0, 4'h3, 0, 4'h1, 8'hA0, 1, 0));
      tbl.push_back(mk(0, 4'h3, 0, 4'h1, 8'hA0, 1, 0));
      tbl.push_back(mk(0, 4'h3, 0, 4'h2, 8'hA1, 1, 0));
      tbl.push_back(mk(0, 4'h3, 0, 4'h2, 8'hA1, 1, 1));
      tbl.push_back(mk(0, 4'h3, 0, 4'h2, 8'hA1, 1, 1));
      tbl.push_back(mk(0, 4'h3, 0, 4'h2, 8'hA1, 1, 1));
      tbl.push_back(mk(0, 4'h3, 0, 4'h1, 8'hA0, 1, 1));
      tbl.push_back(mk(0, 4'h3, 0, 4'h1, 8'hA0, 1, 0));
      tbl.push_back(mk(1, 4'h1, 0, 4'h1, 8'hA0, 0, 0));
      tbl.push_back(mk(0, 4'h1, 0, 4'h1, 8'hA0, 1, 0));
      tbl.push_back(mk(0, 4'h1, 1, 4'h0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 4'h1, 1, 4'h0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 4'h1, 1, 4'h0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 4'h1, 0, 4'h1, 8'hA0, 1, 0));
      tbl.push_back(mk(0, 4'h1, 0, 4'h1, 8'hA0, 1, 0));
      tbl.push_back(mk(0, 4'h3, 0, 4'h2, 8'hA1, 1, 0));
      tbl.push_back(mk(1, 4'hF, 0, 4'h1, 8'hA0, 0, 0));
      tbl.push_back(mk(0, 4'hE, 0, 4'h2, 8'hA1, 1, 0));
      tbl.push_back(mk(0, 4'hC, 0, 4'h4, 8'hA2, 1, 1));
      tbl.push_back(mk(0, 4'h8, 0, 4'h8, 8'hA3, 1, 2));
      tbl.push_back(mk(0, 4'h1, 0, 4'h1, 8'hA0, 1, 3));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 8'h00, 1, 0));
      tbl.push_back(mk(0, 4'h0, 0, 4'h0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'h4, 1, 4'h0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'h4, 0, 4'h4, 8'hA2, 0, 0));

      for (int r = 0; r < tbl.size(); r++) begin
         v = tbl[r];
         if (v.rst) do_reset();
         @(negedge clk);
         data_in = 32'hA3A2A1A0; req = v.req; fifo_full = v.full;
         #1;
         check($sformatf("tbl%0d_ack", r), ack, v.ack);
         check($sformatf("tbl%0d_wr", r), fifo_wr, |v.ack);
         check($sformatf("tbl%0d_dat", r), fifo_wr_data, v.dat);
         check($sformatf("tbl%0d_vld", r), owner_vld, v.vld);
         check($sformatf("tbl%0d_id", r), owner_id, v.id);
      end

      // --- 6: async reset mid-burst of requester 2, then 1 wins from 0110
      do_reset();
      repeat (3) begin
         @(negedge clk);
         req = 4'b0100;
      end
      #1;
      check("mid_pre_ack", ack, 4'b0100);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_vld", owner_vld, 0);
      check("mid_rst_ack", ack, 0);
      check("mid_rst_wr", fifo_wr, 0);
      @(negedge clk);
      reset = 1'b1; req = 4'b0110;
      #1;
      check("mid_after_ack", ack, 4'b0010);
      model_reset();

      // --- randomized run against reference model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) < 3) req = 4'($urandom);
         fifo_full = ($urandom_range(0, 3) == 0);
         data_in   = $urandom;
         stat_clr  = ($urandom_range(0, 199) == 0);
         stat_sel  = 3'($urandom_range(0, 7));
         #1;
         keep = (m_vld != 0 && req[m_id] && m_cnt < MB) ? 1 : 0;
         cand = -1;
         if (keep != 0) cand = m_id;
         else begin
            for (int k = 1; k <= N; k++) begin
               if (cand < 0 && req[(m_last + k) % N]) cand = (m_last + k) % N;
            end
         end
         rdat = data_in;
         exp_ack = 0; exp_dat = 0;
         if (cand >= 0 && !fifo_full) begin
            exp_ack = 1 << cand;
            exp_dat = (rdat >> (cand * W)) & 32'hFF;
         end
`ifdef FIFO_ARB_STATS_EN
         exp_stat = (stat_sel < N) ? m_stat[stat_sel] : 0;
`else
         exp_stat = 0;
`endif
         check("rnd_ack", ack, exp_ack);
         check("rnd_wr", fifo_wr, exp_ack != 0);
         check("rnd_dat", fifo_wr_data, exp_dat);
         check("rnd_vld", owner_vld, m_vld);
         check("rnd_id", owner_id, m_id);
         check("rnd_stat", stat_cnt, exp_stat);
         if (exp_ack != 0) begin
            if (keep != 0) m_cnt++;
            else begin m_id = cand; m_cnt = 1; end
            m_vld = 1; m_last = cand;
            if (m_stat[cand] < 65535) m_stat[cand]++;
         end else if (req == 0) begin
            m_vld = 0;
         end
         if (stat_clr) for (int i = 0; i < N; i++) m_stat[i] = 0;
      end
      stat_clr = 1'b0;

`ifdef FIFO_ARB_STATS_EN
      // counter saturation, out-of-range select, and clear
      do_reset();
      @(negedge clk);
      req = 4'b0001; fifo_full = 1'b0; stat_sel = 3'd0;
      repeat (65540) @(negedge clk);
      #1;
      check("sat_cnt", stat_cnt, 16'hFFFF);
      stat_sel = 3'd7;
      #1;
      check("sel_oob", stat_cnt, 0);
      @(negedge clk);
      stat_sel = 3'd0; stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #1;
      check("clr_cnt", stat_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
